// File: rtl/sdram_arbit_if.sv
// Command-bus bundle between the SDRAM sub-modules (init, refresh,
// write, read) and the command arbiter, plus the chip-side command pins.
// The data bus sdram_dq stays a plain inout port on the arbiter.
`timescale 1ns/1ps
interface sdram_arbit_if;
    // init sub-module
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    // auto-refresh sub-module
    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    // write sub-module
    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_data;
    // read sub-module
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    // grants and watchdog
    logic        aref_en;
    logic        wr_en;
    logic        rd_en;
    logic        arb_timeout;
    // chip command pins
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    // Requester side: drives requests and command buses, sees grants and pins.
    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en, arb_timeout,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr
    );

    // Arbiter side.
    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en, arb_timeout,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter. Holds the command bus on the init sequence until
// init_end, then grants it to one of refresh / write / read at a time.
// Refresh always wins arbitration; write and read alternate on a tie.
// A watchdog releases a grant that is held for TIMEOUT cycles without
// the requester's end pulse.
`timescale 1ns/1ps
module sdram_arbit #(
    parameter int         TIMEOUT = 1023,
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    sdram_arbit_if.slave  bus,
    inout  wire  [15:0]   sdram_dq
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    // A grant is held for at most TIMEOUT cycles: the release edge is the
    // one at which the counter already shows TIMEOUT-1.
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);
    localparam logic [9:0] WD_MAX  = 10'h3FF;

    state_t      state;
    state_t      last_grant;
    logic [9:0]  wd_cnt;
    logic        grant_end;
    logic [3:0]  cmd_mux;
    logic [1:0]  ba_mux;
    logic [12:0] addr_mux;

    // End pulse of whichever requester currently owns the bus; end pulses
    // from anyone else are ignored.
    always_comb begin
        grant_end = 1'b0;
        case (state)
            AREF:    grant_end = bus.aref_end;
            WRITE:   grant_end = bus.wr_end;
            READ:    grant_end = bus.rd_end;
            default: grant_end = 1'b0;
        endcase
    end

    // Arbitration FSM, grant registers and watchdog.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            last_grant  <= READ;
            wd_cnt      <= 10'd0;
            bus.aref_en <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.arb_timeout <= 1'b0;
        end else begin
            bus.arb_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.init_end) begin
                        state <= ARBIT;
                    end
                end
                ARBIT: begin
                    wd_cnt <= 10'd0;
                    if (bus.aref_req) begin
                        state       <= AREF;
                        bus.aref_en <= 1'b1;
                    end else if (bus.wr_req && bus.rd_req) begin
                        if (last_grant == WRITE) begin
                            state      <= READ;
                            last_grant <= READ;
                            bus.rd_en  <= 1'b1;
                        end else begin
                            state      <= WRITE;
                            last_grant <= WRITE;
                            bus.wr_en  <= 1'b1;
                        end
                    end else if (bus.wr_req) begin
                        state      <= WRITE;
                        last_grant <= WRITE;
                        bus.wr_en  <= 1'b1;
                    end else if (bus.rd_req) begin
                        state      <= READ;
                        last_grant <= READ;
                        bus.rd_en  <= 1'b1;
                    end
                end
                AREF, WRITE, READ: begin
                    if (grant_end || (wd_cnt == WD_LAST)) begin
                        // An end pulse on the timeout cycle counts as a
                        // normal completion, so no timeout is flagged.
                        state           <= ARBIT;
                        bus.aref_en     <= 1'b0;
                        bus.wr_en       <= 1'b0;
                        bus.rd_en       <= 1'b0;
                        bus.arb_timeout <= ~grant_end;
                    end else if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Command pin mux, decoded from the current owner of the bus.
    always_comb begin
        cmd_mux  = CMD_NOP;
        ba_mux   = 2'b00;
        addr_mux = 13'h0000;
        case (state)
            IDLE: begin
                cmd_mux  = bus.init_cmd;
                ba_mux   = bus.init_ba;
                addr_mux = bus.init_addr;
            end
            AREF: begin
                cmd_mux  = bus.aref_cmd;
                ba_mux   = bus.aref_ba;
                addr_mux = bus.aref_addr;
            end
            WRITE: begin
                cmd_mux  = bus.wr_cmd;
                ba_mux   = bus.wr_ba;
                addr_mux = bus.wr_addr;
            end
            READ: begin
                cmd_mux  = bus.rd_cmd;
                ba_mux   = bus.rd_ba;
                addr_mux = bus.rd_addr;
            end
            default: begin
                cmd_mux  = CMD_NOP;
                ba_mux   = 2'b00;
                addr_mux = 13'h0000;
            end
        endcase
    end

    assign bus.sdram_cke   = 1'b1;
    assign bus.sdram_cs_n  = cmd_mux[3];
    assign bus.sdram_ras_n = cmd_mux[2];
    assign bus.sdram_cas_n = cmd_mux[1];
    assign bus.sdram_we_n  = cmd_mux[0];
    assign bus.sdram_ba    = ba_mux;
    assign bus.sdram_addr  = addr_mux;

    // The data bus is only ever driven during the data phase of a granted write.
    assign sdram_dq = ((state == WRITE) && bus.wr_sdram_en) ? bus.wr_data : {16{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit (watchdog shortened to 16 cycles).
`timescale 1ns/1ps
module tb_sdram_arbit;

    localparam logic [3:0]  NOP     = 4'b0111;
    localparam logic [3:0]  I_CMD   = 4'b0010;
    localparam logic [1:0]  I_BA    = 2'b01;
    localparam logic [12:0] I_ADDR  = 13'h0400;
    localparam logic [3:0]  A_CMD   = 4'b0001;
    localparam logic [1:0]  A_BA    = 2'b11;
    localparam logic [12:0] A_ADDR  = 13'h0ACE;
    localparam logic [3:0]  W_CMD   = 4'b0100;
    localparam logic [1:0]  W_BA    = 2'b10;
    localparam logic [12:0] W_ADDR  = 13'h0123;
    localparam logic [3:0]  R_CMD   = 4'b0101;
    localparam logic [1:0]  R_BA    = 2'b01;
    localparam logic [12:0] R_ADDR  = 13'h1ABC;

    logic        sys_clk;
    logic        sys_rst;
    logic        tb_dq_oe;
    logic [15:0] tb_dq;
    wire  [15:0] sdram_dq;
    int          ncmp;
    int          nerr;

    sdram_arbit_if bus ();

    sdram_arbit #(.TIMEOUT(16), .CMD_NOP(4'b0111)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bus      (bus),
        .sdram_dq (sdram_dq)
    );

    // Stand-in for the SDRAM chip driving read data onto the shared bus.
    assign sdram_dq = tb_dq_oe ? tb_dq : {16{1'bz}};

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pins();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
    endfunction

    function automatic logic [2:0] grants();
        return {bus.aref_en, bus.wr_en, bus.rd_en};
    endfunction

    initial begin
        ncmp = 0;
        nerr = 0;
        tb_dq_oe = 1'b0;
        tb_dq    = 16'h0000;
        sys_rst  = 1'b1;
        bus.init_end = 1'b0;  bus.init_cmd = I_CMD;  bus.init_ba = I_BA;  bus.init_addr = I_ADDR;
        bus.aref_req = 1'b0;  bus.aref_end = 1'b0;
        bus.aref_cmd = A_CMD; bus.aref_ba = A_BA;    bus.aref_addr = A_ADDR;
        bus.wr_req = 1'b0;    bus.wr_end = 1'b0;     bus.wr_cmd = W_CMD;
        bus.wr_ba = W_BA;     bus.wr_addr = W_ADDR;  bus.wr_sdram_en = 1'b0; bus.wr_data = 16'h0000;
        bus.rd_req = 1'b0;    bus.rd_end = 1'b0;     bus.rd_cmd = R_CMD;
        bus.rd_ba = R_BA;     bus.rd_addr = R_ADDR;

        // Reset state
        tick();
        tick();
        chk("rst_grants", 32'(grants()), 32'(3'b000));
        chk("rst_timeout", 32'(bus.arb_timeout), 32'd0);
        chk("rst_cke", 32'(bus.sdram_cke), 32'd1);
        chk("rst_cmd", 32'(pins()), 32'(I_CMD));

        // 1: no traffic before init_end
        sys_rst = 1'b0;
        bus.wr_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("t1_hold_wr_en", 32'(bus.wr_en), 32'd0);
        end
        chk("t1_init_cmd", 32'(pins()), 32'(I_CMD));
        chk("t1_init_ba", 32'(bus.sdram_ba), 32'(I_BA));
        chk("t1_init_addr", 32'(bus.sdram_addr), 32'(I_ADDR));
        bus.init_end = 1'b1;
        tick();
        chk("t1_arbit_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t1_arbit_nop", 32'(pins()), 32'(NOP));
        chk("t1_arbit_ba", 32'(bus.sdram_ba), 32'd0);
        chk("t1_arbit_addr", 32'(bus.sdram_addr), 32'd0);
        tick();
        chk("t1_wr_grant", 32'(grants()), 32'(3'b010));
        chk("t1_wr_cmd", 32'(pins()), 32'(W_CMD));
        chk("t1_wr_addr", 32'(bus.sdram_addr), 32'(W_ADDR));
        bus.wr_req = 1'b0;
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        chk("t1_wr_release", 32'(grants()), 32'(3'b000));

        // 2: priority and alternation (fresh reset so write wins first tie)
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        chk("t2_arbit_nop", 32'(pins()), 32'(NOP));
        bus.aref_req = 1'b1;
        bus.wr_req   = 1'b1;
        bus.rd_req   = 1'b1;
        tick();
        chk("t2_aref_first", 32'(grants()), 32'(3'b100));
        chk("t2_aref_cmd", 32'(pins()), 32'(A_CMD));
        chk("t2_aref_ba", 32'(bus.sdram_ba), 32'(A_BA));
        bus.aref_req = 1'b0;
        tick();
        tick();
        chk("t2_aref_held", 32'(grants()), 32'(3'b100));
        bus.aref_end = 1'b1;
        tick();
        bus.aref_end = 1'b0;
        chk("t2_aref_release", 32'(grants()), 32'(3'b000));
        tick();
        chk("t2_wr_after_aref", 32'(grants()), 32'(3'b010));
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        chk("t2_foreign_end_ignored", 32'(grants()), 32'(3'b010));
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        chk("t2_wr_release", 32'(grants()), 32'(3'b000));
        tick();
        chk("t2_rd_alternate", 32'(grants()), 32'(3'b001));
        chk("t2_rd_cmd", 32'(pins()), 32'(R_CMD));
        chk("t2_rd_addr", 32'(bus.sdram_addr), 32'(R_ADDR));
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        chk("t2_rd_release", 32'(grants()), 32'(3'b000));
        tick();
        chk("t2_wr_alternate", 32'(grants()), 32'(3'b010));

        // 3: data bus drive only during write
        bus.wr_sdram_en = 1'b1;
        bus.wr_data     = 16'h00A5;
        #1;
        chk("t3_dq_write", 32'(sdram_dq), 32'h00A5);
        bus.wr_sdram_en = 1'b0;
        bus.wr_req = 1'b0;
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        tick();
        chk("t3_rd_grant", 32'(grants()), 32'(3'b001));
        bus.wr_sdram_en = 1'b1;
        tb_dq_oe = 1'b1;
        tb_dq    = 16'h5A00;
        #1;
        chk("t3_dq_read_not_driven", 32'(sdram_dq), 32'h5A00);
        tb_dq_oe = 1'b0;
        bus.wr_sdram_en = 1'b0;

        // 4: watchdog release after 16 cycles
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        tick();
        chk("t4_rd_grant", 32'(grants()), 32'(3'b001));
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("t4_rd_held", 32'(bus.rd_en), 32'd1);
            chk("t4_no_early_timeout", 32'(bus.arb_timeout), 32'd0);
        end
        tick();
        chk("t4_rd_released", 32'(bus.rd_en), 32'd0);
        chk("t4_timeout_pulse", 32'(bus.arb_timeout), 32'd1);
        chk("t4_timeout_nop", 32'(pins()), 32'(NOP));
        bus.rd_req = 1'b0;
        tick();
        chk("t4_timeout_one_cycle", 32'(bus.arb_timeout), 32'd0);
        // end pulse on the timeout cycle wins
        bus.rd_req = 1'b1;
        tick();
        chk("t4b_rd_grant", 32'(grants()), 32'(3'b001));
        for (int i = 1; i < 16; i++) begin
            tick();
        end
        chk("t4b_rd_still_held", 32'(bus.rd_en), 32'd1);
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        bus.rd_req = 1'b0;
        chk("t4b_rd_released", 32'(bus.rd_en), 32'd0);
        chk("t4b_no_timeout", 32'(bus.arb_timeout), 32'd0);
        tick();
        chk("t4b_no_timeout_later", 32'(bus.arb_timeout), 32'd0);

        // 5: reset during a driven write
        bus.wr_req = 1'b1;
        tick();
        chk("t5_wr_grant", 32'(grants()), 32'(3'b010));
        bus.wr_sdram_en = 1'b1;
        bus.wr_data     = 16'h1234;
        #1;
        chk("t5_dq_driven", 32'(sdram_dq), 32'h1234);
        sys_rst = 1'b1;
        tick();
        chk("t5_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t5_rst_idle_pins", 32'(pins()), 32'(I_CMD));
        tb_dq_oe = 1'b1;
        tb_dq    = 16'h0C00;
        #1;
        chk("t5_rst_dq_released", 32'(sdram_dq), 32'h0C00);
        tb_dq_oe = 1'b0;
        bus.wr_sdram_en = 1'b0;
        sys_rst = 1'b0;
        bus.init_end = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_regrant", 32'(bus.wr_en), 32'd0);
        end
        bus.init_end = 1'b1;
        tick();
        chk("t5_arbit_first", 32'(bus.wr_en), 32'd0);
        tick();
        chk("t5_regrant", 32'(grants()), 32'(3'b010));

        // 6: refresh during write waits, then beats pending read
        bus.rd_req = 1'b1;
        tick();
        tick();
        tick();
        bus.aref_req = 1'b1;
        tick();
        tick();
        chk("t6_no_preempt", 32'(grants()), 32'(3'b010));
        bus.wr_req = 1'b0;
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        chk("t6_arbit_gap", 32'(grants()), 32'(3'b000));
        tick();
        chk("t6_aref_beats_rd", 32'(grants()), 32'(3'b100));
        bus.aref_req = 1'b0;
        bus.aref_end = 1'b1;
        tick();
        bus.aref_end = 1'b0;
        tick();
        chk("t6_rd_after_aref", 32'(grants()), 32'(3'b001));
        bus.rd_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Command arbiter inside sdram_ctrl. Sits between the init, auto-refresh, write and read sub-modules and the SDRAM pins.
- Holds off all traffic until initialization completes. Then grants the single command bus to one requester at a time:
  - auto-refresh first;
  - write/read alternate fairly when both pend.
- Muxes the granted requester's command/bank/address onto the chip interface and drives sdram_dq during writes.
- A watchdog recovers the bus if a granted requester never signals completion.

Parameters:
TIMEOUT, 1023, max cycles a grant may be held before forced release (10-bit counter)
CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} NOP encoding

Ports:
sys_clk  in  1  controller clock (100 MHz)
sys_rst  in  1  synchronous reset, active-high
init_end  in  1  init sequence complete (level, stays high)
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_ba  in  2  init bank
init_addr  in  13  init address
aref_req  in  1  refresh request (level until aref_en seen)
aref_end  in  1  refresh done, 1-cycle pulse
aref_cmd/aref_ba/aref_addr  in  4/2/13  refresh command bus
wr_req  in  1  write burst request (level)
wr_end  in  1  write burst done, 1-cycle pulse
wr_cmd/wr_ba/wr_addr  in  4/2/13  write command bus
wr_sdram_en  in  1  write data phase, enables dq drive
wr_data  in  16  write data
rd_req  in  1  read burst request (level)
rd_end  in  1  read burst done, 1-cycle pulse
rd_cmd/rd_ba/rd_addr  in  4/2/13  read command bus
aref_en  out  1  refresh grant
wr_en  out  1  write grant
rd_en  out  1  read grant
arb_timeout  out  1  1-cycle pulse on watchdog release
sdram_cke  out  1  clock enable
sdram_cs_n/sdram_ras_n/sdram_cas_n/sdram_we_n  out  1 each  command pins
sdram_ba  out  2  bank
sdram_addr  out  13  address
sdram_dq  inout  16  data bus

Behaviour:
- States: IDLE, ARBIT, AREF, WRITE, READ. Reset -> IDLE.
- Reset values: aref_en=wr_en=rd_en=0, arb_timeout=0, last_grant=READ (so write wins the first tie), watchdog counter=0, sdram_cke=1.
- Command pins in reset/IDLE follow the init bus.
- IDLE -> ARBIT on init_end=1. Pins = init_* while in IDLE.
- ARBIT priority, evaluated each cycle:
  - aref_req -> AREF;
  - else wr_req & rd_req -> the type opposite last_grant;
  - else wr_req -> WRITE;
  - else rd_req -> READ;
  - else stay.
- Grant latency:
  - Request sampled in ARBIT at edge N. State and the matching *_en register go high at edge N+1.
  - *_en stays high until the requester's *_end is sampled. *_en drops on that same edge as the return to ARBIT.
  - last_grant updates on entry to WRITE/READ. AREF does not change last_grant.
- End-of-grant:
  - New arbitration occurs the cycle after returning to ARBIT; minimum one ARBIT cycle between grants.
  - A request held across an *_end is re-granted only via ARBIT.
  - *_end pulses from non-granted requesters are ignored.
- Pin mux (combinational on state):
  - ARBIT: NOP, ba=2'b00, addr=13'h0000.
  - AREF/WRITE/READ: the matching *_cmd/*_ba/*_addr.
- sdram_dq = wr_data when state==WRITE and wr_sdram_en=1, else high-Z. Never driven in any other state, even if wr_sdram_en=1.
- Watchdog:
  - Counter clears on entry to AREF/WRITE/READ and increments each cycle in those states.
  - On reaching TIMEOUT without *_end: state -> ARBIT, *_en -> 0, arb_timeout pulses for 1 cycle.
  - Counter saturates; it cannot wrap.
  - If *_end and timeout occur on the same cycle, *_end wins: no arb_timeout pulse.
- Refresh arriving during WRITE/READ is not pre-emptive. It waits in ARBIT and beats any pending wr/rd.
- sys_rst mid-grant: next edge returns to IDLE and clears all *_en and the counter. dq goes high-Z immediately after that edge. init_end must then be re-seen.

Test Plan:
1. Reset, hold init_end=0 for 50 cycles with wr_req=1 -> wr_en stays 0, pins follow init_cmd. Raise init_end -> ARBIT next cycle, wr_en=1 one cycle later.
2. In ARBIT assert aref_req, wr_req, rd_req on the same cycle -> aref_en first. After aref_end, wr_en. After wr_end (reqs held), rd_en. After rd_end, wr_en again, confirming alternation.
3. WRITE grant with wr_sdram_en=1, wr_data=16'h00A5 -> sdram_dq=16'h00A5. In READ with wr_sdram_en forced 1 -> sdram_dq=16'hzzzz.
4. TIMEOUT=16, grant rd with rd_end never pulsed -> after 16 cycles rd_en=0 and arb_timeout=1 for exactly 1 cycle. Variant with rd_end on cycle 16 -> no arb_timeout pulse.
5. Assert sys_rst for 1 cycle mid-WRITE with dq driven -> next edge wr_en=0, state IDLE, dq high-Z. wr_req held -> no regrant until init_end is observed.
6. aref_req rises 3 cycles into a write burst -> no pre-emption. aref_en rises 2 cycles after wr_end (one ARBIT cycle, then grant), ahead of a pending rd_req.
